// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multiport register file: 2 comb reads, byte-masked write, clear sequencer
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      clear,
    input  logic [ADDR_WIDTH-1:0]     readReg1,
    input  logic [ADDR_WIDTH-1:0]     readReg2,
    input  logic [ADDR_WIDTH-1:0]     writeReg,
    input  logic [DATA_WIDTH-1:0]     writeData,
    input  logic [DATA_WIDTH/8-1:0]   writeMask,
    input  logic                      write,
    output logic [DATA_WIDTH-1:0]     readData1,
    output logic [DATA_WIDTH-1:0]     readData2,
    output logic                      ready
);

    localparam int DEPTH  = 2**ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH/8;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   clear_ptr_q;
    logic                    ready_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic wr_zero;
    logic wr_en;

    assign wr_zero = (ZERO_REG != 0) && (writeReg == '0);
    // clear wins over a write sampled on the same edge
    assign wr_en   = (state_q == ST_READY) && !clear && write && !wr_zero;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_CLEAR;
            clear_ptr_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clear_ptr_q <= clear_ptr_q + 1'b1;
                    if (clear_ptr_q == {ADDR_WIDTH{1'b1}}) begin
                        state_q     <= ST_READY;
                        ready_q     <= 1'b1;
                        clear_ptr_q <= '0;
                    end
                end
                ST_READY: begin
                    if (clear) begin
                        state_q     <= ST_CLEAR;
                        clear_ptr_q <= '0;
                        ready_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_CLEAR;
                    clear_ptr_q <= '0;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset; holding resetN low must not zero entries by itself
    always_ff @(posedge clk) begin
        if (resetN) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clear_ptr_q] <= '0;
            end else if (wr_en) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (writeMask[b]) begin
                        mem_q[writeReg][8*b +: 8] <= writeData[8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [NBYTES-1:0]     mask
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < NBYTES; b++) begin
            if (mask[b]) begin
                r[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return r;
    endfunction
`endif

    always_comb begin
        readData1 = mem_q[readReg1];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (writeReg == readReg1)) begin
            readData1 = merge_bytes(mem_q[readReg1], writeData, writeMask);
        end
`endif
        if (!ready_q || ((ZERO_REG != 0) && (readReg1 == '0))) begin
            readData1 = '0;
        end
    end

    always_comb begin
        readData2 = mem_q[readReg2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (writeReg == readReg2)) begin
            readData2 = merge_bytes(mem_q[readReg2], writeData, writeMask);
        end
`endif
        if (!ready_q || ((ZERO_REG != 0) && (readReg2 == '0))) begin
            readData2 = '0;
        end
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - self-checking bench for regfile_multiport (default parameters)
module tb_regfile_multiport;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        resetN;
    logic        clear;
    logic [4:0]  readReg1, readReg2, writeReg;
    logic [31:0] writeData;
    logic [3:0]  writeMask;
    logic        write;
    logic [31:0] readData1, readData2;
    logic        ready;

    regfile_multiport dut (
        .clk       (clk),
        .resetN    (resetN),
        .clear     (clear),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .writeReg  (writeReg),
        .writeData (writeData),
        .writeMask (writeMask),
        .write     (write),
        .readData1 (readData1),
        .readData2 (readData2),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: stored values plus count of clearing edges still owed
    logic [31:0] mem_m [DEPTH];
    int          busy;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] v;
        if (busy != 0 || a == 5'd0) return 32'h0;
        v = mem_m[a];
`ifdef REGFILE_BYPASS_EN
        if (write && !clear && writeReg == a) v = merge(v, writeData, writeMask);
`endif
        return v;
    endfunction

    task automatic model_edge();
        if (!resetN) begin
            busy = DEPTH;
        end else if (busy > 0) begin
            mem_m[DEPTH - busy] = 32'h0;
            busy--;
        end else if (clear) begin
            busy = DEPTH;
        end else if (write && writeReg != 5'd0) begin
            mem_m[writeReg] = merge(mem_m[writeReg], writeData, writeMask);
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{5'd7,  32'hdddddddd, 4'b1111, 5'd7,  5'd8,  32'hdddddddd, 32'h00000000};
        vecs[1] = '{5'd7,  32'h11111111, 4'b0011, 5'd7,  5'd8,  32'hdddd1111, 32'h00000000};
        vecs[2] = '{5'd0,  32'haaaaaaaa, 4'b1111, 5'd0,  5'd7,  32'h00000000, 32'hdddd1111};
        vecs[3] = '{5'd7,  32'hffffffff, 4'b0000, 5'd7,  5'd0,  32'hdddd1111, 32'h00000000};
        vecs[4] = '{5'd31, 32'h12345678, 4'b1010, 5'd31, 5'd31, 32'h12005600, 32'h12005600};

        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        busy = DEPTH;
        resetN = 1'b0; clear = 1'b0; write = 1'b0;
        readReg1 = 5'd3; readReg2 = 5'd4; writeReg = 5'd0; writeData = 32'h0; writeMask = 4'h0;

        @(negedge clk);
        #1;
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_rd1", readData1, 32'h0);
        chk("reset_rd2", readData2, 32'h0);
        cycle();

        resetN = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("init_ready_low", 32'(ready), 32'h0);
            chk("init_rd1_zero", readData1, 32'h0);
            cycle();
        end
        #1;
        chk("init_ready_high", 32'(ready), 32'h1);
        cycle();
        for (int a = 0; a < DEPTH; a++) begin
            readReg1 = 5'(a);
            readReg2 = 5'(DEPTH - 1 - a);
            #1;
            chk("init_all_zero_p1", readData1, 32'h0);
            chk("init_all_zero_p2", readData2, 32'h0);
            cycle();
        end

        for (int i = 0; i < 5; i++) begin
            write = 1'b1;
            writeReg = vecs[i].waddr; writeData = vecs[i].wdata; writeMask = vecs[i].wmask;
            readReg1 = 5'd1; readReg2 = 5'd2;
            cycle();
            write = 1'b0;
            readReg1 = vecs[i].r1; readReg2 = vecs[i].r2;
            #1;
            chk("vec_rd1", readData1, vecs[i].e1);
            chk("vec_rd2", readData2, vecs[i].e2);
            cycle();
        end

        write = 1'b1; writeReg = 5'd13; writeData = 32'haaaaaaaa; writeMask = 4'hf;
        readReg1 = 5'd13; readReg2 = 5'd13;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_rd1", readData1, 32'haaaaaaaa);
        chk("same_cycle_rd2", readData2, 32'haaaaaaaa);
`else
        chk("same_cycle_rd1", readData1, 32'h0);
        chk("same_cycle_rd2", readData2, 32'h0);
`endif
        cycle();
        write = 1'b0;
        #1;
        chk("after_edge_rd1", readData1, 32'haaaaaaaa);
        cycle();

        // clear pulse with a simultaneous write: write is dropped
        clear = 1'b1; write = 1'b1; writeReg = 5'd11; writeData = 32'h15828762; writeMask = 4'hf;
        readReg1 = 5'd11; readReg2 = 5'd7;
        cycle();
        clear = 1'b0; write = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("clear_ready_low", 32'(ready), 32'h0);
            cycle();
        end
        #1;
        chk("clear_ready_high", 32'(ready), 32'h1);
        chk("clear_reg11", readData1, 32'h0);
        chk("clear_reg7", readData2, 32'h0);
        cycle();

        write = 1'b1; writeReg = 5'd14; writeData = 32'h5a5a5a5a; writeMask = 4'hf;
        cycle();
        write = 1'b0;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        resetN = 1'b0;
        busy = DEPTH;
        #1;
        chk("midclear_reset_ready", 32'(ready), 32'h0);
        cycle();
        resetN = 1'b1;
        write = 1'b1; writeReg = 5'd14; writeData = 32'hffffffff; writeMask = 4'hf;
        readReg1 = 5'd14;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("restart_ready_low", 32'(ready), 32'h0);
            cycle();
        end
        write = 1'b0;
        #1;
        chk("restart_ready_high", 32'(ready), 32'h1);
        chk("restart_reg14", readData1, 32'h0);
        cycle();

        for (int i = 0; i < 400; i++) begin
            clear     = ($urandom_range(0, 59) == 0);
            write     = 1'($urandom_range(0, 1));
            writeReg  = 5'($urandom_range(0, 15));
            writeData = $urandom;
            writeMask = 4'($urandom);
            readReg1  = ($urandom_range(0, 2) == 0) ? writeReg : 5'($urandom_range(0, 15));
            readReg2  = 5'($urandom_range(0, 15));
            #1;
            chk("rand_ready", 32'(ready), (busy == 0) ? 32'h1 : 32'h0);
            chk("rand_rd1", readData1, model_read(readReg1));
            chk("rand_rd2", readData2, model_read(readReg2));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
